// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing a multicycle RV32I-subset datapath (lw, sw, R, I-ALU, beq/bne, jal).
// Ports: clk/reset (async, active-high); opcode/funct3/zero/mem_ready in; PC/IR/regfile/memory enables,
// address/ALU/result selects, imm_src (combinational from opcode), sticky halt and debug state out.
module multicycle_controller #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_req,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic       halt,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4, MEMWRITE = 4'd5,
    EXECR = 4'd6, ALUWB = 4'd7, EXECI = 4'd8, JAL = 4'd9, BRANCH = 4'd10, TRAP = 4'd11
  } state_t;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_B = 7'b1100011, OP_JAL = 7'b1101111;
  state_t cur, nxt;
  logic rdy;
  assign rdy = mem_ready | ~MEM_WAIT_EN;
  assign state = cur;
  assign halt = cur == TRAP;
  assign imm_src = opcode == OP_SW ? 2'b01 : opcode == OP_B ? 2'b10 : opcode == OP_JAL ? 2'b11 : 2'b00;
  always_ff @(posedge clk or posedge reset)
    if (reset) cur <= FETCH;
    else cur <= nxt;
  always_comb begin
    nxt = cur;
    pc_write = 1'b0;
    ir_write = 1'b0;
    adr_src = 1'b0;
    mem_req = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    alu_op = 2'b00;
    result_src = 2'b00;
    case (cur)
      FETCH: begin
        mem_req = 1'b1;
        alu_src_b = 2'b10;
        result_src = 2'b10;
        ir_write = rdy;
        pc_write = rdy;
        nxt = rdy ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        nxt = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
              opcode == OP_R ? EXECR : opcode == OP_I ? EXECI :
              opcode == OP_B ? BRANCH : opcode == OP_JAL ? JAL : TRAP;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        nxt = opcode == OP_SW ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        nxt = rdy ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write = 1'b1;
        nxt = FETCH;
      end
      MEMWRITE: begin
        mem_req = 1'b1;
        mem_write = 1'b1;
        adr_src = 1'b1;
        nxt = rdy ? FETCH : MEMWRITE;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_op = 2'b10;
        nxt = ALUWB;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op = 2'b10;
        nxt = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        nxt = FETCH;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write = 1'b1;
        nxt = ALUWB;
      end
      BRANCH: begin
        alu_src_a = 2'b10;
        alu_op = 2'b01;
        pc_write = (funct3 == 3'b000 & zero) | (funct3 == 3'b001 & ~zero);
        nxt = FETCH;
      end
      TRAP: nxt = TRAP;
      default: nxt = FETCH;
    endcase
    // Async reset forces FETCH immediately; enables must also drop within that same cycle.
    if (reset) begin
      pc_write = 1'b0;
      ir_write = 1'b0;
      mem_req = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed per-cycle vectors checked by a negedge scoreboard monitor.
module tb_multicycle_controller;
  logic clk = 1'b0, reset = 1'b1;
  logic [6:0] opcode = 7'b0000011;
  logic [2:0] funct3 = 3'b000;
  logic zero = 1'b0, mem_ready = 1'b1;
  logic pc_write, ir_write, adr_src, mem_req, mem_write, reg_write, halt;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, imm_src;
  logic [3:0] state;
  multicycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src), .mem_req(mem_req), .mem_write(mem_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .result_src(result_src), .imm_src(imm_src), .halt(halt), .state(state)
  );
  always #5 clk = ~clk;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011,
                         BR = 7'b1100011, JL = 7'b1101111, BAD = 7'b0000000;
  // enables {pc_write, ir_write, adr_src, mem_req, mem_write, reg_write, halt}
  localparam logic [6:0] E0 = 7'b0000000, EF = 7'b1101000, EFS = 7'b0001000, EMR = 7'b0011000,
                         EMW = 7'b0011100, ERW = 7'b0000010, EPW = 7'b1000000, EH = 7'b0000001;
  // selects {alu_src_a, alu_src_b, alu_op, result_src}
  localparam logic [7:0] SF = 8'b00_10_00_10, SD = 8'b01_01_00_00, SMA = 8'b10_01_00_00, SZ = 8'b0,
                         SWB = 8'b00_00_00_01, SER = 8'b10_00_10_00, SEI = 8'b10_01_10_00,
                         SJ = 8'b01_10_00_00, SB = 8'b10_00_01_00;
  typedef struct packed { logic [3:0] st; logic [6:0] en; logic [7:0] sel; logic [1:0] imm; } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0, step = 0;
  wire [20:0] act = {state, pc_write, ir_write, adr_src, mem_req, mem_write, reg_write, halt,
                     alu_src_a, alu_src_b, alu_op, result_src, imm_src};
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      step++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL cycle_%0d: got st=%0d en=%b sel=%b imm=%b, want st=%0d en=%b sel=%b imm=%b",
                 step, act[20:17], act[16:10], act[9:2], act[1:0], e.st, e.en, e.sel, e.imm);
      end
    end
  task automatic cyc(input logic r, input logic late, input logic [6:0] op, input logic [2:0] f3,
                     input logic z, input logic rdy, input logic [3:0] st, input logic [6:0] en,
                     input logic [7:0] sel, input logic [1:0] imm);
    opcode = op;
    funct3 = f3;
    zero = z;
    mem_ready = rdy;
    reset = r;
    if (late) begin
      #2;
      reset = 1'b1;
    end
    q.push_back('{st, en, sel, imm});
    @(posedge clk);
    #1;
  endtask
  initial begin
    @(posedge clk);
    #1;
    cyc(1, 0, LW, 0, 0, 1, 0, E0, SF, 2'b00);
    cyc(0, 0, LW, 0, 0, 1, 0, EF, SF, 2'b00);
    cyc(0, 0, LW, 0, 0, 1, 1, E0, SD, 2'b00);
    cyc(0, 0, LW, 0, 0, 1, 2, E0, SMA, 2'b00);
    cyc(0, 0, LW, 0, 0, 1, 3, EMR, SZ, 2'b00);
    cyc(0, 0, LW, 0, 0, 1, 4, ERW, SWB, 2'b00);
    cyc(0, 0, BR, 0, 1, 1, 0, EF, SF, 2'b10);
    cyc(0, 0, BR, 0, 1, 1, 1, E0, SD, 2'b10);
    cyc(0, 0, BR, 0, 1, 1, 10, EPW, SB, 2'b10);
    cyc(0, 0, BR, 0, 0, 1, 0, EF, SF, 2'b10);
    cyc(0, 0, BR, 0, 0, 1, 1, E0, SD, 2'b10);
    cyc(0, 0, BR, 0, 0, 1, 10, E0, SB, 2'b10);
    cyc(0, 0, BR, 1, 1, 1, 0, EF, SF, 2'b10);
    cyc(0, 0, BR, 1, 1, 1, 1, E0, SD, 2'b10);
    cyc(0, 0, BR, 1, 1, 1, 10, E0, SB, 2'b10);
    cyc(0, 0, BR, 1, 0, 1, 0, EF, SF, 2'b10);
    cyc(0, 0, BR, 1, 0, 1, 1, E0, SD, 2'b10);
    cyc(0, 0, BR, 1, 0, 1, 10, EPW, SB, 2'b10);
    cyc(0, 0, BR, 3'b100, 1, 1, 0, EF, SF, 2'b10);
    cyc(0, 0, BR, 3'b100, 1, 1, 1, E0, SD, 2'b10);
    cyc(0, 0, BR, 3'b100, 1, 1, 10, E0, SB, 2'b10);
    cyc(0, 0, RT, 0, 0, 0, 0, EFS, SF, 2'b00);
    cyc(0, 0, RT, 0, 0, 0, 0, EFS, SF, 2'b00);
    cyc(0, 0, RT, 0, 0, 1, 0, EF, SF, 2'b00);
    cyc(0, 0, RT, 0, 0, 1, 1, E0, SD, 2'b00);
    cyc(0, 0, RT, 0, 0, 1, 6, E0, SER, 2'b00);
    cyc(0, 0, RT, 0, 0, 1, 7, ERW, SZ, 2'b00);
    cyc(0, 0, IT, 0, 0, 1, 0, EF, SF, 2'b00);
    cyc(0, 0, IT, 0, 0, 1, 1, E0, SD, 2'b00);
    cyc(0, 0, IT, 0, 0, 1, 8, E0, SEI, 2'b00);
    cyc(0, 0, IT, 0, 0, 1, 7, ERW, SZ, 2'b00);
    cyc(0, 0, SW, 0, 0, 1, 0, EF, SF, 2'b01);
    cyc(0, 0, SW, 0, 0, 1, 1, E0, SD, 2'b01);
    cyc(0, 0, SW, 0, 0, 1, 2, E0, SMA, 2'b01);
    cyc(0, 0, SW, 0, 0, 0, 5, EMW, SZ, 2'b01);
    cyc(0, 0, SW, 0, 0, 1, 5, EMW, SZ, 2'b01);
    cyc(0, 0, JL, 0, 0, 1, 0, EF, SF, 2'b11);
    cyc(0, 0, JL, 0, 0, 1, 1, E0, SD, 2'b11);
    cyc(0, 0, JL, 0, 0, 1, 9, EPW, SJ, 2'b11);
    cyc(0, 0, JL, 0, 0, 1, 7, ERW, SZ, 2'b11);
    cyc(0, 0, BAD, 0, 0, 1, 0, EF, SF, 2'b00);
    cyc(0, 0, BAD, 0, 0, 1, 1, E0, SD, 2'b00);
    for (int i = 0; i < 10; i++) cyc(0, 0, BAD, 0, 0, 1, 11, EH, SZ, 2'b00);
    cyc(1, 0, BAD, 0, 0, 1, 0, E0, SF, 2'b00);
    cyc(0, 0, SW, 0, 0, 1, 0, EF, SF, 2'b01);
    cyc(0, 0, SW, 0, 0, 1, 1, E0, SD, 2'b01);
    cyc(0, 0, SW, 0, 0, 1, 2, E0, SMA, 2'b01);
    cyc(0, 0, SW, 0, 0, 0, 5, EMW, SZ, 2'b01);
    cyc(0, 1, SW, 0, 0, 0, 0, E0, SF, 2'b01);
    cyc(1, 0, SW, 0, 0, 1, 0, E0, SF, 2'b01);
    cyc(0, 0, SW, 0, 0, 1, 0, EF, SF, 2'b01);
    cyc(0, 0, SW, 0, 0, 1, 1, E0, SD, 2'b01);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
